// File: rtl/an_code_pkg.sv
// Shared definitions for the AN-code encoder/decoder family: FSM states,
// default code constants and a constant-width helper.
package an_code_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        SEARCH,
        DONE
    } state_t;

    localparam int DEFAULT_A      = 83;
    localparam int DEFAULT_W_BITS = 38;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) result = b + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/an_seq_divider.sv
// Bit-serial restoring divider by the constant A: one quotient bit per cycle,
// MSB first. q and r present the final values combinationally while done is high.
module an_seq_divider
    import an_code_pkg::*;
#(
    parameter int A      = DEFAULT_A,
    parameter int A_BITS = 7,
    parameter int W_BITS = DEFAULT_W_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_BITS-1:0] dividend,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] q,
    output logic [A_BITS:0]   r
);

    localparam int              C_BITS = clog2(W_BITS);
    localparam logic [A_BITS:0] A_EXT  = (A_BITS + 1)'(A);
    localparam logic [C_BITS-1:0] LAST = C_BITS'(W_BITS - 1);

    logic [W_BITS-1:0] shift_q, quo_q, quo_next;
    logic [A_BITS-1:0] rem_q;
    logic [A_BITS:0]   trial, rem_next;
    logic [C_BITS-1:0] cnt_q;
    logic              busy_q, take;

    always_comb begin
        trial    = {rem_q, shift_q[W_BITS-1]};
        take     = (trial >= A_EXT);
        rem_next = take ? trial - A_EXT : trial;
        quo_next = {quo_q[W_BITS-2:0], take};
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST);
    assign q    = quo_next;
    assign r    = rem_next;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            shift_q <= dividend;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shift_q <= {shift_q[W_BITS-2:0], 1'b0};
            quo_q   <= quo_next;
            rem_q   <= rem_next[A_BITS-1:0];
            cnt_q   <= cnt_q + C_BITS'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/an_sec_decoder_seq.sv
// Handshaked AN-code single-error-correcting decoder: divides W by A, then walks
// 2^i mod A to locate a +/-2^i error without a syndrome table.
module an_sec_decoder_seq
    import an_code_pkg::*;
#(
    parameter int A      = DEFAULT_A,
    parameter int A_BITS = 7,
    parameter int W_BITS = DEFAULT_W_BITS,
    parameter int N_BITS = 31,
    parameter int L_MAX  = 41,
    parameter int P_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] W,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] N,
    output logic              corrected,
    output logic [P_BITS-1:0] err_pos,
    output logic              err_sign,
    output logic              uncorrectable
);

    localparam logic [A_BITS:0] A_EXT = (A_BITS + 1)'(A);

    state_t            state_q, state_d;
    logic [W_BITS-1:0] q_q, k_q, k_next, div_q;
    logic [A_BITS:0]   r_q, p_q, p_dbl, p_next, div_r;
    logic [P_BITS-1:0] i_q;
    logic [W_BITS:0]   ncand;
    logic              accept, div_busy, div_done;
    logic              pos_hit, neg_hit, hit, in_range, last_idx, p_wrap;

    logic [N_BITS-1:0] n_q;
    logic [P_BITS-1:0] err_pos_q;
    logic              corrected_q, err_sign_q, unc_q;

    assign accept = in_valid && in_ready && !div_busy;

    an_seq_divider #(.A(A), .A_BITS(A_BITS), .W_BITS(W_BITS)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept),
        .dividend (W),
        .busy     (div_busy),
        .done     (div_done),
        .q        (div_q),
        .r        (div_r)
    );

    // Invariant while searching: 2^i = A*k + p, so W -/+ 2^i divides by A
    // exactly when r matches p or A-p.
    always_comb begin
        pos_hit  = (r_q == p_q);
        neg_hit  = !pos_hit && (r_q == A_EXT - p_q);
        hit      = pos_hit || neg_hit;
        ncand    = pos_hit ? ({1'b0, q_q} - {1'b0, k_q})
                           : ({1'b0, q_q} + {1'b0, k_q} + (W_BITS + 1)'(1));
        in_range = (ncand[W_BITS:N_BITS] == '0);
        last_idx = (i_q == P_BITS'(L_MAX - 1));
        p_dbl    = {p_q[A_BITS-1:0], 1'b0};
        p_wrap   = (p_dbl >= A_EXT);
        p_next   = p_wrap ? p_dbl - A_EXT : p_dbl;
        k_next   = {k_q[W_BITS-2:0], 1'b0} + W_BITS'(p_wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DIV;
            DIV:     if (div_done) state_d = (div_r == '0) ? DONE : SEARCH;
            SEARCH:  if (hit || last_idx) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == IDLE);
        out_valid     = (state_q == DONE);
        N             = n_q;
        corrected     = corrected_q;
        err_pos       = err_pos_q;
        err_sign      = err_sign_q;
        uncorrectable = unc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= '0;
            r_q         <= '0;
            p_q         <= '0;
            k_q         <= '0;
            i_q         <= '0;
            n_q         <= '0;
            corrected_q <= 1'b0;
            err_pos_q   <= '0;
            err_sign_q  <= 1'b0;
            unc_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    n_q         <= '0;
                    corrected_q <= 1'b0;
                    err_pos_q   <= '0;
                    err_sign_q  <= 1'b0;
                    unc_q       <= 1'b0;
                end
                DIV: if (div_done) begin
                    q_q <= div_q;
                    r_q <= div_r;
                    p_q <= (A_BITS + 1)'(1);
                    k_q <= '0;
                    i_q <= '0;
                    if (div_r == '0) n_q <= div_q[N_BITS-1:0];
                end
                SEARCH: begin
                    if (hit && in_range) begin
                        n_q         <= ncand[N_BITS-1:0];
                        corrected_q <= 1'b1;
                        err_pos_q   <= i_q;
                        err_sign_q  <= neg_hit;
                    end else if (hit || last_idx) begin
                        n_q   <= q_q[N_BITS-1:0];
                        unc_q <= 1'b1;
                    end else begin
                        p_q <= p_next;
                        k_q <= k_next;
                        i_q <= i_q + P_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Self-checking bench for an_sec_decoder_seq: directed words, randomized words
// against an arithmetic reference model, backpressure and mid-search reset.
module tb_an_sec_decoder_seq;

    localparam int A = 83, A_BITS = 7, W_BITS = 38, N_BITS = 31, L_MAX = 41, P_BITS = 6;
    localparam int L_SHORT = 8;

    typedef struct {
        longint n;
        bit     corr;
        int     pos;
        bit     sign;
        bit     unc;
        int     lat;
    } exp_t;

    logic              clk, rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [W_BITS-1:0] W;
    logic [N_BITS-1:0] N;
    logic              corrected, err_sign, uncorrectable;
    logic [P_BITS-1:0] err_pos;

    logic              in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [W_BITS-1:0] W_s;
    logic [N_BITS-1:0] N_s;
    logic              corrected_s, err_sign_s, uncorrectable_s;
    logic [P_BITS-1:0] err_pos_s;

    int checks = 0;
    int failures = 0;

    an_sec_decoder_seq #(.A(A), .A_BITS(A_BITS), .W_BITS(W_BITS), .N_BITS(N_BITS),
                         .L_MAX(L_MAX), .P_BITS(P_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .W(W),
        .out_valid(out_valid), .out_ready(out_ready), .N(N), .corrected(corrected),
        .err_pos(err_pos), .err_sign(err_sign), .uncorrectable(uncorrectable)
    );

    an_sec_decoder_seq #(.A(A), .A_BITS(A_BITS), .W_BITS(W_BITS), .N_BITS(N_BITS),
                         .L_MAX(L_SHORT), .P_BITS(P_BITS)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s), .W(W_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .N(N_s), .corrected(corrected_s),
        .err_pos(err_pos_s), .err_sign(err_sign_s), .uncorrectable(uncorrectable_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the error is +/-2^i when W -/+ 2^i is a multiple of A; the
    // first index (positive before negative) that works decides the result.
    function automatic exp_t model(input longint w, input int l_max);
        exp_t   e;
        longint q, r;
        q      = w / A;
        r      = w % A;
        e.n    = q & ((longint'(1) << N_BITS) - 1);
        e.corr = 0;
        e.pos  = 0;
        e.sign = 0;
        e.unc  = 0;
        e.lat  = W_BITS + 1;
        if (r == 0) return e;
        for (int i = 0; i < l_max; i++) begin
            longint pw, cand;
            bit     found, neg;
            pw    = longint'(1) << i;
            found = 0;
            neg   = 0;
            cand  = 0;
            if (pw % A == r) begin
                found = 1;
                cand  = (w - pw) / A;
            end else if (A - (pw % A) == r) begin
                found = 1;
                neg   = 1;
                cand  = (w + pw) / A;
            end
            if (found) begin
                e.lat = W_BITS + 2 + i;
                if (cand < 0 || cand >= (longint'(1) << N_BITS)) begin
                    e.unc = 1;
                end else begin
                    e.corr = 1;
                    e.pos  = i;
                    e.sign = neg;
                    e.n    = cand;
                end
                return e;
            end
        end
        e.unc = 1;
        e.lat = W_BITS + 1 + l_max;
        return e;
    endfunction

    task automatic send(input logic [W_BITS-1:0] w);
        in_valid = 1'b1;
        W        = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called one cycle after the accept edge; waits for out_valid and checks the result.
    task automatic collect(input exp_t e, input string name);
        int cyc;
        logic [N_BITS+P_BITS+2:0] got, want;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, cyc);
            return;
        end
        if (cyc != e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
        end
        checks++;
        got  = {N, corrected, err_pos, err_sign, uncorrectable};
        want = {e.n[N_BITS-1:0], e.corr, e.pos[P_BITS-1:0], e.sign, e.unc};
        if (got !== want) begin
            failures++;
            $display("FAIL %s result: got N=%0d corr=%0b pos=%0d sign=%0b unc=%0b expected N=%0d corr=%0b pos=%0d sign=%0b unc=%0b",
                     name, N, corrected, err_pos, err_sign, uncorrectable,
                     e.n, e.corr, e.pos, e.sign, e.unc);
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: got out_valid=%0b in_ready=%0b expected 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, N, corrected, err_pos, err_sign, uncorrectable} !==
            {1'b1, 1'b0, {N_BITS{1'b0}}, 1'b0, {P_BITS{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got in_ready=%0b out_valid=%0b N=%0d corr=%0b pos=%0d sign=%0b unc=%0b expected 1 0 0 0 0 0 0",
                     in_ready, out_valid, N, corrected, err_pos, err_sign, uncorrectable);
        end
    endtask

    task automatic test_directed();
        logic [W_BITS-1:0] words [5] = '{38'd83000, 38'd83008, 38'd82996, 38'd83128, 38'd5};
        exp_t              table_e [5] = '{
            '{1000, 0, 0, 0, 0, 39},
            '{1000, 1, 3, 0, 0, 43},
            '{1000, 1, 2, 1, 0, 42},
            '{1000, 1, 7, 0, 0, 47},
            '{0,    0, 0, 0, 1, 67}
        };
        for (int t = 0; t < 5; t++) begin
            send(words[t]);
            collect(table_e[t], $sformatf("directed_W%0d", words[t]));
            release_result("directed");
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            longint            data, tmp;
            int                kind, idx;
            logic [W_BITS-1:0] w;
            data = longint'($urandom() & 32'h7fff_ffff);
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, L_MAX - 1);
            tmp  = data * A;
            case (kind)
                1:       tmp = tmp + (longint'(1) << idx);
                2:       tmp = tmp - (longint'(1) << idx);
                3:       tmp = {$urandom(), $urandom()};
                default: ;
            endcase
            w = tmp[W_BITS-1:0];
            send(w);
            collect(model(longint'(w), L_MAX), $sformatf("random%0d_W%0d", t, w));
            release_result("random");
        end
    endtask

    task automatic test_no_match();
        int cyc;
        in_valid_s = 1'b1;
        W_s        = 38'd83003;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        cyc = 1;
        while (!out_valid_s && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!out_valid_s || cyc != 47) begin
            failures++;
            $display("FAIL no_match latency: got cycle %0d valid=%0b expected 47", cyc, out_valid_s);
        end
        checks++;
        if ({N_s, corrected_s, err_pos_s, err_sign_s, uncorrectable_s} !==
            {31'd1000, 1'b0, 6'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL no_match result: got N=%0d corr=%0b pos=%0d sign=%0b unc=%0b expected N=1000 unc=1",
                     N_s, corrected_s, err_pos_s, err_sign_s, uncorrectable_s);
        end
        out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        e1 = model(longint'(83008), L_MAX);
        e2 = model(longint'(83128), L_MAX);
        send(38'd83008);
        collect(e1, "bp_first");
        in_valid = 1'b1;
        W        = 38'd83128;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, N, corrected, err_pos, err_sign, uncorrectable} !==
                {1'b1, 1'b0, e1.n[N_BITS-1:0], e1.corr, e1.pos[P_BITS-1:0], e1.sign, e1.unc}) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%0b ready=%0b N=%0d corr=%0b pos=%0d expected valid=1 ready=0 N=%0d corr=%0b pos=%0d",
                         c, out_valid, in_ready, N, corrected, err_pos, e1.n, e1.corr, e1.pos);
            end
        end
        release_result("bp");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: got in_ready=%0b expected 0 after accept", in_ready);
        end
        collect(e2, "bp_second");
        release_result("bp_second");
    endtask

    task automatic test_reset_mid();
        send(38'd5);
        repeat (45) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, N, corrected, err_pos, err_sign, uncorrectable} !==
            {1'b1, 1'b0, {N_BITS{1'b0}}, 1'b0, {P_BITS{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset outputs: got ready=%0b valid=%0b N=%0d corr=%0b unc=%0b expected 1 0 0 0 0",
                     in_ready, out_valid, N, corrected, uncorrectable);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset release: got ready=%0b valid=%0b expected 1 0", in_ready, out_valid);
        end
        send(38'd82996);
        collect(model(longint'(82996), L_MAX), "after_reset");
        release_result("after_reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        W           = '0;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b0;
        W_s         = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_directed();
        test_random();
        test_no_match();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
